// File: rtl/lbp_engine_p.sv
// Local-binary-pattern engine: scans an IMG_W x IMG_H gray image in raster order
// and writes one 8-bit LBP code per target pixel, with optional border fill.
module lbp_engine_p #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int DW     = 8,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [DW-1:0]     gray_data,
    input  logic [DW-1:0]     thresh,
    input  logic              border_fill,
    output logic              lbp_valid,
    input  logic              lbp_ready,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic [7:0]        lbp_data,
    output logic              finish
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ_C = 3'd1,
        NEIGH  = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [RW-1:0]     row, row_n;
    logic [CW-1:0]     col, col_n;
    logic [ADDR_W-1:0] pix_addr, addr_n;
    logic [ADDR_W-1:0] nb_addr;
    logic [DW-1:0]     center;
    logic [DW-1:0]     thr_q;
    logic              fill_q;
    logic [7:0]        acc;
    logic [2:0]        k;

    logic [CW-1:0]     first_col, last_col;
    logic [RW-1:0]     last_row;
    logic              is_last;
    logic              next_border;
    logic [DW:0]       ref_sum;
    logic              ge;

    // Scan window: full frame with border fill, otherwise the interior only.
    always_comb begin
        first_col   = fill_q ? '0 : CW'(1);
        last_col    = fill_q ? CW'(IMG_W - 1) : CW'(IMG_W - 2);
        last_row    = fill_q ? RW'(IMG_H - 1) : RW'(IMG_H - 2);
        is_last     = (row == last_row) && (col == last_col);
        if (col == last_col) begin
            col_n  = first_col;
            row_n  = row + RW'(1);
            addr_n = pix_addr + (fill_q ? ADDR_W'(1) : ADDR_W'(3));
        end else begin
            col_n  = col + CW'(1);
            row_n  = row;
            addr_n = pix_addr + ADDR_W'(1);
        end
        next_border = fill_q && ((row_n == '0) || (row_n == RW'(IMG_H - 1)) ||
                                 (col_n == '0) || (col_n == CW'(IMG_W - 1)));
    end

    // Neighbour k address, NW first, SE last; only used on interior pixels.
    always_comb begin
        nb_addr = pix_addr;
        case (k)
            3'd0:    nb_addr = pix_addr - ROW_STEP - ADDR_W'(1);
            3'd1:    nb_addr = pix_addr - ROW_STEP;
            3'd2:    nb_addr = pix_addr - ROW_STEP + ADDR_W'(1);
            3'd3:    nb_addr = pix_addr - ADDR_W'(1);
            3'd4:    nb_addr = pix_addr + ADDR_W'(1);
            3'd5:    nb_addr = pix_addr + ROW_STEP - ADDR_W'(1);
            3'd6:    nb_addr = pix_addr + ROW_STEP;
            default: nb_addr = pix_addr + ROW_STEP + ADDR_W'(1);
        endcase
    end

    // One extra bit keeps center + thresh from wrapping or saturating.
    always_comb begin
        ref_sum = {1'b0, center} + {1'b0, thr_q};
        ge      = ({1'b0, gray_data} >= ref_sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (gray_ready) begin
                    state_n = border_fill ? WRITE : READ_C;
                end
            end
            READ_C: state_n = NEIGH;
            NEIGH: begin
                if (k == 3'd7) begin
                    state_n = WRITE;
                end
            end
            WRITE: begin
                if (lbp_ready) begin
                    if (is_last) begin
                        state_n = DONE;
                    end else begin
                        state_n = next_border ? WRITE : READ_C;
                    end
                end
            end
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row      <= '0;
            col      <= '0;
            pix_addr <= '0;
            center   <= '0;
            thr_q    <= '0;
            fill_q   <= 1'b0;
            acc      <= '0;
            k        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gray_ready) begin
                        thr_q    <= thresh;
                        fill_q   <= border_fill;
                        row      <= border_fill ? '0 : RW'(1);
                        col      <= border_fill ? '0 : CW'(1);
                        pix_addr <= border_fill ? '0 : ADDR_W'(IMG_W + 1);
                        acc      <= '0;
                        k        <= '0;
                    end
                end
                READ_C: begin
                    center <= gray_data;
                    acc    <= '0;
                    k      <= '0;
                end
                NEIGH: begin
                    acc[k] <= ge;
                    k      <= k + 3'd1;
                end
                WRITE: begin
                    // acc is cleared on advance so border pixels write 0.
                    if (lbp_ready && !is_last) begin
                        row      <= row_n;
                        col      <= col_n;
                        pix_addr <= addr_n;
                        acc      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write handshake: lbp_valid rises in WRITE and a beat transfers on any
    // cycle with lbp_valid && lbp_ready; address and data hold until then.
    always_comb begin
        gray_req  = 1'b0;
        gray_addr = '0;
        lbp_valid = 1'b0;
        lbp_addr  = '0;
        lbp_data  = '0;
        finish    = 1'b0;
        case (state)
            READ_C: begin
                gray_req  = 1'b1;
                gray_addr = pix_addr;
            end
            NEIGH: begin
                gray_req  = 1'b1;
                gray_addr = nb_addr;
            end
            WRITE: begin
                lbp_valid = 1'b1;
                lbp_addr  = pix_addr;
                lbp_data  = acc;
            end
            DONE:    finish = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/lbp_engine_p.md
Name: lbp_engine_p

Overview:
Parametrised local-binary-pattern engine for the grayscale image pipeline. Reads an IMG_W x IMG_H image from gray memory, computes an 8-bit LBP code per pixel, and writes it to result memory. Compared with the fixed 128x128 engine, it adds:
- generic image and pixel size
- an optional comparison threshold
- an optional full-frame border fill
- write-side back-pressure

Parameters:
IMG_W, 128, image width in pixels (>=3)
IMG_H, 128, image height in pixels (>=3)
DW, 8, gray pixel width in bits
ADDR_W, 14, address width; IMG_W*IMG_H <= 2**ADDR_W

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
gray_ready  in  1  image available; level, sampled in IDLE
gray_req  out  1  read strobe; gray_data valid in the same cycle
gray_addr  out  ADDR_W  read address = row*IMG_W + col
gray_data  in  DW  read data, combinational from gray_addr
thresh  in  DW  comparison offset, sampled when leaving IDLE
border_fill  in  1  1 = also write border pixels as 0; sampled when leaving IDLE
lbp_valid  out  1  write strobe
lbp_ready  in  1  result memory accepts the write when high with lbp_valid
lbp_addr  out  ADDR_W  write address = row*IMG_W + col
lbp_data  out  8  LBP code; 0 when lbp_valid is low
finish  out  1  frame complete; held high until reset

Behaviour:
- Reset values: all outputs 0; state IDLE; row/col set to the first target pixel on leaving IDLE.
- States: IDLE, READ_C, NEIGH, WRITE, DONE.
- Scan order: raster order, col fastest.
  - border_fill=0: rows 1..IMG_H-2, cols 1..IMG_W-2.
  - border_fill=1: rows 0..IMG_H-1, cols 0..IMG_W-1.
- IDLE: when gray_ready=1, latch thresh and border_fill, load the first pixel, then go to READ_C. If that pixel is a border pixel (row 0 or IMG_H-1, or col 0 or IMG_W-1), go to WRITE instead.
- READ_C: 1 cycle.
  - gray_req=1, gray_addr = center address.
  - Latch center = gray_data; clear the accumulator; k=0; go to NEIGH.
- NEIGH: 8 cycles, k=0..7.
  - gray_req=1; gray_addr = neighbour k.
  - Neighbour order and offsets: 0 NW(-W-1), 1 N(-W), 2 NE(-W+1), 3 W(-1), 4 E(+1), 5 SW(+W-1), 6 S(+W), 7 SE(+W+1).
  - Compare with an (DW+1)-bit sum, no saturation and no wrap: bit k = 1 iff gray_data >= center + thresh.
  - After k=7, go to WRITE.
- WRITE:
  - lbp_valid=1, lbp_addr = current pixel, lbp_data = accumulated code (0 for border pixels).
  - gray_req=0.
  - Holds while lbp_ready=0; lbp_addr and lbp_data stay stable.
  - On lbp_ready=1:
    - If this is the last pixel of the scan, go to DONE.
    - Otherwise advance to the next pixel (col wraps to the first column, row+1) and go to READ_C, or stay in WRITE if the next pixel is a border pixel.
- DONE: finish=1; no further reads or writes; ignores gray_ready. Leaves only on reset.
- Latency per pixel, with lbp_ready=1:
  - interior: 10 cycles (1 center + 8 neighbour + 1 write)
  - border: 1 cycle
- Throughput at lbp_ready=1:
  - border_fill=0: frame takes 10*(IMG_W-2)*(IMG_H-2) cycles after IDLE exits.
- Mutual exclusion: gray_req and lbp_valid are never high in the same cycle.
- Reset mid-frame: returns to IDLE immediately and drops all strobes. The next gray_ready restarts from the first pixel.
- Changes to thresh or border_fill mid-frame have no effect until the next frame.

Test Plan:
- Constant image, IMG_W=IMG_H=4, every pixel 50, thresh=0, border_fill=0:
  - exactly 4 writes, to addrs 5, 6, 9, 10, each with data 0xFF
  - then finish=1 and stays high
- Same image with thresh=1: all 4 codes are 0x00.
- 4x4 image with pixel value = addr (0..15), thresh=0:
  - addr 5 -> 0xF0 (center 5; only SW/S/SE/E are >= 5)
  - addr 10 -> 0xF0
- border_fill=1 on the 4x4 constant image:
  - 16 writes in addr order 0..15
  - the 12 border addrs get 0x00; addrs 5, 6, 9, 10 get 0xFF
  - border writes perform no gray reads (gray_req low)
- lbp_ready held low 5 cycles on the first write:
  - lbp_valid, lbp_addr=5 and lbp_data stay stable
  - no gray_req until the write is accepted; the remaining codes are unchanged
- Reset asserted during NEIGH of addr 6:
  - all outputs go to 0 in the same cycle
  - after release and gray_ready=1, writing restarts at addr 5 with correct codes
